// File: rtl/conv_weight_streamer_pkg.sv
// Shared definitions for the conv weight streamer: widths, size helpers, FSM encoding.
package conv_weight_streamer_pkg;

    localparam int CWS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } cws_state_e;

    function automatic int weight_num(input int cin, input int cout, input int k);
        return cin * cout * k * k;
    endfunction

    // Counter must be able to hold the terminal value itself, hence n+1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_weight_rd_pipe.sv
// Return path of the weight memory: read-enable delay, output registers and return counter.
// Only this module knows the memory read latency.
module conv_weight_rd_pipe
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = CWS_DATA_WIDTH,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_out,
    output logic [CNT_WIDTH-1:0]  ret_cnt
);

    logic                  rd_vld_q, rd_vld_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] weight_q, weight_d;
    logic [CNT_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;

    always_comb begin
        rd_vld_d  = rd_en;
        valid_d   = rd_vld_q;
        weight_d  = weight_q;
        ret_cnt_d = ret_cnt_q;
        if (rd_vld_q) begin
            weight_d  = rd_data;
            ret_cnt_d = ret_cnt_q + CNT_WIDTH'(1);
        end
        if (clr) begin
            ret_cnt_d = '0;
        end
    end

    // Reset drops any read still in flight so it never reaches the stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            valid_q   <= 1'b0;
            weight_q  <= '0;
            ret_cnt_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            valid_q   <= valid_d;
            weight_q  <= weight_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign weight_out = weight_q;
    assign valid_out  = valid_q;
    assign ret_cnt    = ret_cnt_q;

endmodule

// File: rtl/conv_weight_streamer.sv
// Streams one conv layer's weight block from on-chip memory, one word per cycle,
// with issue throttled by pause.
module conv_weight_streamer
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH      = CWS_DATA_WIDTH,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int KERNEL          = 1,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  busy,
    output logic                  done
);

    localparam int WEIGHT_NUM = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
    localparam int CNT_WIDTH  = cnt_width(WEIGHT_NUM);
    localparam logic [CNT_WIDTH-1:0] WN_C = CNT_WIDTH'(WEIGHT_NUM);

    cws_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]  ret_cnt;
    logic                  rd_en;
    logic                  clr;
    logic                  busy_c;
    logic                  done_c;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        rd_en       = 1'b0;
        clr         = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    issue_cnt_d = '0;
                    clr         = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy_c = 1'b1;
                if (!pause && (issue_cnt_q < WN_C)) begin
                    rd_en       = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
                end
                if (issue_cnt_d == WN_C) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_c = 1'b1;
                if (ret_cnt == WN_C) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Address wraps modulo 2^ADDR_WIDTH; range checking belongs to the sequencer.
    assign mem_rd_en = rd_en;
    assign mem_addr  = base_q + ADDR_WIDTH'(issue_cnt_q);
    assign busy      = busy_c;
    assign done      = done_c;

    conv_weight_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .rd_en      (rd_en),
        .rd_data    (mem_rd_data),
        .weight_out (weight_out),
        .valid_out  (valid_weight_out),
        .ret_cnt    (ret_cnt)
    );

endmodule

// File: tb/tb_conv_weight_streamer.sv
// Directed bench for conv_weight_streamer: 4x2x1x1 layer (8 words), memory returns its address.
module tb_conv_weight_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        pause;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic [31:0] weight_out;
    logic        valid_weight_out;
    logic        busy;
    logic        done;

    logic        start_w;
    logic [3:0]  base_w;
    logic        pause_w;
    logic        mem_rd_en_w;
    logic [3:0]  mem_addr_w;
    logic [31:0] mem_rd_data_w;
    logic [31:0] weight_out_w;
    logic        valid_w;
    logic        busy_w;
    logic        done_w;

    int nvec = 0;
    int nmis = 0;

    conv_weight_streamer #(
        .DATA_WIDTH(32), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2), .KERNEL(1), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .pause(pause),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .weight_out(weight_out), .valid_weight_out(valid_weight_out), .busy(busy), .done(done)
    );

    conv_weight_streamer #(
        .DATA_WIDTH(32), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2), .KERNEL(1), .ADDR_WIDTH(4)
    ) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .base_addr(base_w), .pause(pause_w),
        .mem_rd_en(mem_rd_en_w), .mem_addr(mem_addr_w), .mem_rd_data(mem_rd_data_w),
        .weight_out(weight_out_w), .valid_weight_out(valid_w), .busy(busy_w), .done(done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory holding value == address; poisoned when not read.
    always @(posedge clk) begin
        mem_rd_data   <= mem_rd_en   ? 32'(mem_addr)   : 32'hDEAD_BEEF;
        mem_rd_data_w <= mem_rd_en_w ? 32'(mem_addr_w) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic        pa;
        logic        rd;
        logic        ca;
        logic [15:0] addr;
        logic        vld;
        logic [31:0] w;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[41];

    function automatic vec_t mk(input int st, input int base, input int pa, input int rd,
                                input int ca, input int addr, input int vld, input int w,
                                input int bsy, input int dn);
        vec_t v;
        v.st = 1'(st); v.base = 16'(base); v.pa = 1'(pa);
        v.rd = 1'(rd); v.ca = 1'(ca); v.addr = 16'(addr);
        v.vld = 1'(vld); v.w = 32'(w); v.busy = 1'(bsy); v.done = 1'(dn);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int cnt;
        int nw;
        int na;
        int nd;

        //           st  base  pa  rd ca addr   vld w     busy done
        // basic stream with ignored starts at row 5 and the FINISH row 11
        tbl[ 0] = mk(1, 'h10,  0,  0, 0, 0,     0, 'h00,  0, 0);
        tbl[ 1] = mk(0, 0,     0,  1, 1, 'h10,  0, 'h00,  1, 0);
        tbl[ 2] = mk(0, 0,     0,  1, 1, 'h11,  0, 'h00,  1, 0);
        tbl[ 3] = mk(0, 0,     0,  1, 1, 'h12,  1, 'h10,  1, 0);
        tbl[ 4] = mk(0, 0,     0,  1, 1, 'h13,  1, 'h11,  1, 0);
        tbl[ 5] = mk(1, 'h100, 0,  1, 1, 'h14,  1, 'h12,  1, 0);
        tbl[ 6] = mk(0, 0,     0,  1, 1, 'h15,  1, 'h13,  1, 0);
        tbl[ 7] = mk(0, 0,     0,  1, 1, 'h16,  1, 'h14,  1, 0);
        tbl[ 8] = mk(0, 0,     0,  1, 1, 'h17,  1, 'h15,  1, 0);
        tbl[ 9] = mk(0, 0,     0,  0, 0, 0,     1, 'h16,  1, 0);
        tbl[10] = mk(0, 0,     0,  0, 0, 0,     1, 'h17,  1, 0);
        tbl[11] = mk(1, 'h100, 0,  0, 0, 0,     0, 'h17,  0, 1);
        // back-to-back start in the cycle after done
        tbl[12] = mk(1, 'h20,  0,  0, 0, 0,     0, 'h17,  0, 0);
        tbl[13] = mk(0, 0,     0,  1, 1, 'h20,  0, 'h17,  1, 0);
        tbl[14] = mk(0, 0,     0,  1, 1, 'h21,  0, 'h17,  1, 0);
        tbl[15] = mk(0, 0,     0,  1, 1, 'h22,  1, 'h20,  1, 0);
        tbl[16] = mk(0, 0,     0,  1, 1, 'h23,  1, 'h21,  1, 0);
        tbl[17] = mk(0, 0,     0,  1, 1, 'h24,  1, 'h22,  1, 0);
        tbl[18] = mk(0, 0,     0,  1, 1, 'h25,  1, 'h23,  1, 0);
        tbl[19] = mk(0, 0,     0,  1, 1, 'h26,  1, 'h24,  1, 0);
        tbl[20] = mk(0, 0,     0,  1, 1, 'h27,  1, 'h25,  1, 0);
        tbl[21] = mk(0, 0,     0,  0, 0, 0,     1, 'h26,  1, 0);
        tbl[22] = mk(0, 0,     0,  0, 0, 0,     1, 'h27,  1, 0);
        tbl[23] = mk(0, 0,     0,  0, 0, 0,     0, 'h27,  0, 1);
        // paused stream: pause on the 3rd..5th cycle after the first read
        tbl[24] = mk(1, 'h10,  0,  0, 0, 0,     0, 'h27,  0, 0);
        tbl[25] = mk(0, 0,     0,  1, 1, 'h10,  0, 'h27,  1, 0);
        tbl[26] = mk(0, 0,     0,  1, 1, 'h11,  0, 'h27,  1, 0);
        tbl[27] = mk(0, 0,     1,  0, 1, 'h12,  1, 'h10,  1, 0);
        tbl[28] = mk(0, 0,     1,  0, 1, 'h12,  1, 'h11,  1, 0);
        tbl[29] = mk(0, 0,     1,  0, 1, 'h12,  0, 'h11,  1, 0);
        tbl[30] = mk(0, 0,     0,  1, 1, 'h12,  0, 'h11,  1, 0);
        tbl[31] = mk(0, 0,     0,  1, 1, 'h13,  0, 'h11,  1, 0);
        tbl[32] = mk(0, 0,     0,  1, 1, 'h14,  1, 'h12,  1, 0);
        tbl[33] = mk(0, 0,     0,  1, 1, 'h15,  1, 'h13,  1, 0);
        tbl[34] = mk(0, 0,     0,  1, 1, 'h16,  1, 'h14,  1, 0);
        tbl[35] = mk(0, 0,     0,  1, 1, 'h17,  1, 'h15,  1, 0);
        tbl[36] = mk(0, 0,     0,  0, 0, 0,     1, 'h16,  1, 0);
        tbl[37] = mk(0, 0,     0,  0, 0, 0,     1, 'h17,  1, 0);
        tbl[38] = mk(0, 0,     0,  0, 0, 0,     0, 'h17,  0, 1);
        // pause while idle does nothing
        tbl[39] = mk(0, 0,     1,  0, 0, 0,     0, 'h17,  0, 0);
        tbl[40] = mk(0, 0,     1,  0, 0, 0,     0, 'h17,  0, 0);

        reset = 1'b0; start = 1'b0; base_addr = '0; pause = 1'b0;
        start_w = 1'b0; base_w = '0; pause_w = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_en",  32'(mem_rd_en), 32'd0);
        check("reset addr",   32'(mem_addr), 32'd0);
        check("reset valid",  32'(valid_weight_out), 32'd0);
        check("reset weight", weight_out, 32'd0);
        check("reset busy",   32'(busy), 32'd0);
        check("reset done",   32'(done), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 41; i++) begin
            start = tbl[i].st; base_addr = tbl[i].base; pause = tbl[i].pa;
            @(negedge clk);
            check($sformatf("r%0d rd_en", i), 32'(mem_rd_en), 32'(tbl[i].rd));
            if (tbl[i].ca) check($sformatf("r%0d addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            check($sformatf("r%0d valid", i), 32'(valid_weight_out), 32'(tbl[i].vld));
            check($sformatf("r%0d weight", i), weight_out, tbl[i].w);
            check($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("r%0d done", i), 32'(done), 32'(tbl[i].done));
            @(posedge clk);
            #1;
        end
        start = 1'b0; pause = 1'b0;

        // reset in the middle of a stream
        start = 1'b1; base_addr = 16'h0030;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 4; k++) begin
            @(negedge clk);
            if (valid_weight_out) cnt++;
        end
        check("rstmid words before reset", 32'(cnt), 32'd4);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid rd_en",  32'(mem_rd_en), 32'd0);
        check("rstmid addr",   32'(mem_addr), 32'd0);
        check("rstmid valid",  32'(valid_weight_out), 32'd0);
        check("rstmid weight", weight_out, 32'd0);
        check("rstmid busy",   32'(busy), 32'd0);
        check("rstmid done",   32'(done), 32'd0);
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_weight_out || busy || done) cnt++;
        end
        check("rstmid quiet after reset", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0040;
        @(posedge clk); #1;
        start = 1'b0;
        nw = 0; nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid_weight_out) begin
                if (nw < 8) check($sformatf("restart w%0d", nw), weight_out, 32'h40 + 32'(nw));
                nw++;
            end
            if (done) nd++;
        end
        check("restart word count", 32'(nw), 32'd8);
        check("restart done count", 32'(nd), 32'd1);
        @(posedge clk); #1;

        // 4-bit address wrap
        start_w = 1'b1; base_w = 4'hE;
        @(posedge clk); #1;
        start_w = 1'b0;
        na = 0; nw = 0; nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_rd_en_w) begin
                if (na < 8) check($sformatf("wrap addr%0d", na), 32'(mem_addr_w), 32'((14 + na) % 16));
                na++;
            end
            if (valid_w) begin
                if (nw < 8) check($sformatf("wrap w%0d", nw), weight_out_w, 32'((14 + nw) % 16));
                nw++;
            end
            if (done_w) nd++;
        end
        check("wrap read count", 32'(na), 32'd8);
        check("wrap word count", 32'(nw), 32'd8);
        check("wrap done count", 32'(nd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
